seg_decode: RTL

SEG_DECODE -- requirements
Module: seg_decode

---
 rtl/seg_decode.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg_decode
// Brief   : Recovers hex digits from a multiplexed active-low 7-segment bus.
// Revision: 1.0 - initial release
// ============================================================================
module seg_decode #(
    parameter int unsigned STABLE = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig,
    output logic [15:0] hex,
    output logic [3:0]  dp,
    output logic [3:0]  valid,
    output logic        upd,
    output logic        bad
);

    localparam logic [7:0] C_STABLE = 8'(STABLE);

    logic [7:0] r_seg_meta;
    logic [7:0] r_seg_sync;
    logic [7:0] r_seg_prev;
    logic [3:0] r_dig_meta;
    logic [3:0] r_dig_sync;
    logic [3:0] r_dig_prev;
    logic [7:0] r_cnt;

    logic       w_same;
    logic       w_cap;
    logic       w_legal;
    logic [3:0] w_nib;
    logic [3:0] w_write;

    assign w_same  = (r_seg_sync == r_seg_prev) && (r_dig_sync == r_dig_prev);
    // Capture fires only on the single edge the counter reaches STABLE, so a held pattern never recaptures.
    assign w_cap   = w_same && (r_cnt == C_STABLE - 8'd1);
    assign w_write = w_cap ? ~r_dig_sync : 4'b0000;

    always_comb begin
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (r_seg_sync[6:0])
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'hA;
            7'h03:   w_nib = 4'hB;
            7'h46:   w_nib = 4'hC;
            7'h21:   w_nib = 4'hD;
            7'h06:   w_nib = 4'hE;
            7'h0E:   w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_meta <= 8'hFF;
            r_seg_sync <= 8'hFF;
            r_seg_prev <= 8'hFF;
            r_dig_meta <= 4'hF;
            r_dig_sync <= 4'hF;
            r_dig_prev <= 4'hF;
            r_cnt      <= 8'd0;
            hex        <= 16'h0000;
            dp         <= 4'h0;
            valid      <= 4'h0;
            upd        <= 1'b0;
            bad        <= 1'b0;
        end else begin
            r_seg_meta <= seg;
            r_seg_sync <= r_seg_meta;
            r_seg_prev <= r_seg_sync;
            r_dig_meta <= dig;
            r_dig_sync <= r_dig_meta;
            r_dig_prev <= r_dig_sync;

            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != C_STABLE) begin
                r_cnt <= r_cnt + 8'd1;
            end

            // An illegal glyph still updates dp but leaves the old nibble in place.
            for (int n = 0; n < 4; n++) begin
                if (w_write[n]) begin
                    dp[n]    <= ~r_seg_sync[7];
                    valid[n] <= w_legal;
                    if (w_legal) begin
                        hex[4*n +: 4] <= w_nib;
                    end
                end
            end

            upd <= |w_write;
            bad <= (|w_write) && !w_legal;
        end
    end

endmodule
`default_nettype wire
